// File: rtl/braille_pkg.sv
// braille_pkg
// Shared definitions for the braille reader front end:
//   - state_e        : reader FSM states
//   - output bit map : positions of the dot field and status flags in cell_out
//   - letter_to_cell : ASCII lower-case letter to 6-dot Grade-1 braille cell
package braille_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_END  = 2'd2
    } state_e;

    localparam int DOTS_LSB    = 0;
    localparam int SHOWING_BIT = 6;
    localparam int AT_END_BIT  = 7;

    // Messages are up to 32 characters. The message parameter is a
    // right-justified string in a fixed-width vector.
    localparam int MSG_MAX_LEN = 32;
    localparam int MSG_W       = 8 * MSG_MAX_LEN;
    localparam int IDX_W       = 5;

    // Bit i of the result is dot i+1. Anything that is not 'a'..'z'
    // (space included) gives an empty cell.
    function automatic logic [5:0] letter_to_cell(input logic [7:0] ascii);
        logic [5:0] dots;
        case (ascii)
            "a": dots = 6'h01;
            "b": dots = 6'h03;
            "c": dots = 6'h09;
            "d": dots = 6'h19;
            "e": dots = 6'h11;
            "f": dots = 6'h0B;
            "g": dots = 6'h1B;
            "h": dots = 6'h13;
            "i": dots = 6'h0A;
            "j": dots = 6'h1A;
            "k": dots = 6'h05;
            "l": dots = 6'h07;
            "m": dots = 6'h0D;
            "n": dots = 6'h1D;
            "o": dots = 6'h15;
            "p": dots = 6'h0F;
            "q": dots = 6'h1F;
            "r": dots = 6'h17;
            "s": dots = 6'h0E;
            "t": dots = 6'h1E;
            "u": dots = 6'h25;
            "v": dots = 6'h27;
            "w": dots = 6'h3A;
            "x": dots = 6'h2D;
            "y": dots = 6'h3D;
            "z": dots = 6'h35;
            default: dots = 6'h00;
        endcase
        return dots;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronises a raw asynchronous push-button, debounces it and emits a
// single-cycle pulse on each accepted press (debounced 0->1). Releases
// produce no pulse.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   btn_i   in  raw button level, asynchronous, active-high
//   rise_o  out one-cycle pulse, high in the cycle after the debounced
//               level goes from 0 to 1
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreeing cycle restarts the stability window.
    // Reaching CNT_LAST while still disagreeing accepts the new level and
    // leaves the counter at zero.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/braille_reader.sv
// braille_reader
// Front-end reader stage: steps through a fixed message one character per
// debounced "next" press and presents each character as a registered
// braille cell word with status flags.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   next_btn  in  raw "next" push-button, asynchronous, active-high
//   restart   in  raw restart request, asynchronous, active-high (level)
//   cell_out  out [5:0] dots 1..6, [6] showing, [7] at_end (registered)
//   char_idx  out index of the character currently selected (debug)
// The FSM state is held in state_q (type state_e) for observation.
module braille_reader
    import braille_pkg::*;
#(
    parameter logic [MSG_W-1:0] MSG             = MSG_W'("hello"),
    parameter int               MSG_LEN         = 5,
    parameter int               DEBOUNCE_CYCLES = 1000,
    parameter int               CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       next_btn,
    input  logic       restart,
    output logic [7:0] cell_out,
    output logic [4:0] char_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [7:0]       cell_q;
    logic [7:0]       cell_d;
    logic             rst_sync1_q;
    logic             rst_sync2_q;
    logic             advance;
    logic [7:0]       msg_chars [MSG_MAX_LEN];

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_next_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (next_btn),
        .rise_o (advance)
    );

    // Character 0 is the most significant byte of the used part of MSG.
    // Unused slots read as 0 so the lookup is a full 5-bit index.
    for (genvar g = 0; g < MSG_MAX_LEN; g++) begin : g_chars
        if (g < MSG_LEN) begin : g_used
            assign msg_chars[g] = MSG[8*(MSG_LEN-1-g) +: 8];
        end else begin : g_unused
            assign msg_chars[g] = 8'h00;
        end
    end

    // State register, restart synchroniser and registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync1_q <= 1'b0;
            rst_sync2_q <= 1'b0;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cell_q      <= 8'h00;
        end else begin
            rst_sync1_q <= restart;
            rst_sync2_q <= rst_sync1_q;
            state_q     <= state_d;
            idx_q       <= idx_d;
            cell_q      <= cell_d;
        end
    end

    // Next-state logic. Restart is a level and wins over a coincident
    // advance, so the press is dropped rather than deferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (rst_sync2_q) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (advance) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                end
                ST_SHOW: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_END;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_END: begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Output logic, decoded from the current state and registered, so the
    // word follows a state change by one cycle.
    always_comb begin
        cell_d = 8'h00;
        case (state_q)
            ST_SHOW: begin
                cell_d[SHOWING_BIT]     = 1'b1;
                cell_d[DOTS_LSB +: 6]   = letter_to_cell(msg_chars[idx_q]);
            end
            ST_END: begin
                cell_d[AT_END_BIT] = 1'b1;
            end
            default: begin
                cell_d = 8'h00;
            end
        endcase
    end

    assign cell_out = cell_q;
    assign char_idx = idx_q;

endmodule

// File: tb/tb_braille_reader.sv
// tb_braille_reader
// Two readers share all inputs: one holds "hello", the other holds the whole
// alphabet plus a space. Expected cells come from a position model and a
// dot-list description of Grade-1 braille.
module tb_braille_reader;

    localparam int DC    = 8;
    localparam int LEN_H = 5;
    localparam int LEN_A = 27;
    localparam int ASC_A = 97;
    localparam int ASC_K = 107;
    localparam int ASC_U = 117;
    localparam int ASC_W = 119;

    // ---------------- clock / reset ----------------
    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       next_btn = 1'b0;
    logic       restart  = 1'b0;
    logic [7:0] cell_h;
    logic [7:0] cell_a;
    logic [4:0] idx_h;
    logic [4:0] idx_a;

    always #5 clk = ~clk;

    braille_reader #(
        .MSG             (256'("hello")),
        .MSG_LEN         (LEN_H),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (16)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .next_btn (next_btn),
        .restart  (restart),
        .cell_out (cell_h),
        .char_idx (idx_h)
    );

    braille_reader #(
        .MSG             (256'("abcdefghijklmnopqrstuvwxyz ")),
        .MSG_LEN         (LEN_A),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (16)
    ) u_abc (
        .clk      (clk),
        .rst_n    (rst_n),
        .next_btn (next_btn),
        .restart  (restart),
        .cell_out (cell_a),
        .char_idx (idx_a)
    );

    // ---------------- reference model ----------------
    // Position: -1 idle, 0..len-1 showing that character, len at end.
    string msg_h = "hello";
    string msg_a = "abcdefghijklmnopqrstuvwxyz ";
    string base_tbl [10] = '{"1", "12", "14", "145", "15",
                             "124", "1245", "125", "24", "245"};
    int pos_h = -1;
    int pos_a = -1;

    function automatic logic [5:0] dots_of(logic [7:0] ch);
        string      d;
        int         c;
        int         n;
        logic [5:0] r;
        r = '0;
        d = "";
        c = int'(ch);
        if (c == ASC_W) begin
            d = "2456";
        end else if (c >= ASC_A && c < ASC_A + 10) begin
            d = base_tbl[c - ASC_A];
        end else if (c >= ASC_K && c < ASC_K + 10) begin
            d = {base_tbl[c - ASC_K], "3"};
        end else if (c >= ASC_U && c <= ASC_U + 5) begin
            n = c - ASC_U;
            if (c > ASC_W) n--;
            d = {base_tbl[n], "36"};
        end
        for (int i = 0; i < d.len(); i++) r[int'(d[i]) - 49] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] model_cell(string m, int pos);
        if (pos < 0) return 8'h00;
        if (pos >= m.len()) return 8'h80;
        return {2'b01, dots_of(m[pos])};
    endfunction

    function automatic int model_step(int pos, int len);
        if (pos < 0 || pos >= len) return 0;
        return pos + 1;
    endfunction

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic score(string tag);
        exp_q.push_back(model_cell(msg_h, pos_h));
        exp_q.push_back(model_cell(msg_a, pos_a));
        chk({tag, "/cell_h"}, cell_h, exp_q.pop_front());
        chk({tag, "/cell_a"}, cell_a, exp_q.pop_front());
        if (pos_h < LEN_H) chk({tag, "/idx_h"}, {3'b000, idx_h}, 8'((pos_h < 0) ? 0 : pos_h));
        if (pos_a < LEN_A) chk({tag, "/idx_a"}, {3'b000, idx_a}, 8'((pos_a < 0) ? 0 : pos_a));
    endtask

    // ---------------- drivers ----------------
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(int hold, int low);
        next_btn = 1'b1;
        tick(hold);
        next_btn = 1'b0;
        tick(low);
        pos_h = model_step(pos_h, LEN_H);
        pos_a = model_step(pos_a, LEN_A);
    endtask

    task automatic rand_press();
        press($urandom_range(20, 10), $urandom_range(16, 12));
    endtask

    // Every high glitch is shorter than the debounce window.
    task automatic bounce_burst(int n);
        for (int i = 0; i < n; i++) begin
            next_btn = 1'b1;
            tick($urandom_range(6, 1));
            next_btn = 1'b0;
            tick($urandom_range(3, 1));
        end
        tick(12);
    endtask

    task automatic restart_pulse(int len);
        restart = 1'b1;
        tick(len);
        restart = 1'b0;
        tick(6);
        pos_h = -1;
        pos_a = -1;
    endtask

    logic [7:0] seq_exp [7] = '{8'h53, 8'h51, 8'h47, 8'h47, 8'h55, 8'h80, 8'h53};

    // ---------------- stimulus ----------------
    initial begin
        int sel;

        // Reset asserted between clock edges must clear outputs at once.
        #2 rst_n = 1'b0;
        #1;
        score("reset_async");
        tick(3);
        rst_n = 1'b1;
        tick(2);
        score("reset_release");

        // First press: exact latency 2 + DC + 1 + 1 edges.
        next_btn = 1'b1;
        tick(DC + 3);
        score("lat_one_early");
        tick(1);
        pos_h = model_step(pos_h, LEN_H);
        pos_a = model_step(pos_a, LEN_A);
        score("lat_exact");
        chk("first_h", cell_h, seq_exp[0]);
        tick(8);
        next_btn = 1'b0;
        tick(14);

        // Presses 2..7: through the word, to the end marker and wrap.
        for (int k = 1; k < 7; k++) begin
            rand_press();
            score("seq");
            chk("seq_const", cell_h, seq_exp[k]);
        end

        // Bounce: 5-high / 3-low glitches never get accepted.
        for (int k = 0; k < 4; k++) begin
            next_btn = 1'b1;
            tick(5);
            next_btn = 1'b0;
            tick(3);
            score("bounce");
        end
        tick(12);
        score("bounce_settled");
        press(10, 14);
        score("bounce_stable");

        // Restart while showing 'l'.
        rand_press();
        score("to_l");
        chk("to_l_const", cell_h, 8'h47);
        restart = 1'b1;
        tick(4);
        chk("restart_cell", cell_h, 8'h00);
        chk("restart_idx", {3'b000, idx_h}, 8'h00);
        restart = 1'b0;
        tick(4);
        pos_h = -1;
        pos_a = -1;
        score("restart");
        rand_press();
        score("after_restart");
        chk("after_restart_const", cell_h, 8'h53);

        // Restart lands on the same cycle as the advance pulse.
        next_btn = 1'b1;
        tick(DC);
        restart = 1'b1;
        tick(4);
        pos_h = -1;
        pos_a = -1;
        score("coincident_edge");
        restart = 1'b0;
        tick(8);
        next_btn = 1'b0;
        tick(14);
        score("coincident_settled");

        // Walk the alphabet reader through every character, end and wrap.
        for (int k = 0; k < LEN_A + 2; k++) begin
            rand_press();
            score("walk");
        end

        // Randomised mix of presses, bounce bursts and restarts.
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(9, 0);
            if (sel < 6) begin
                rand_press();
                score("rnd_press");
            end else if (sel < 9) begin
                bounce_burst($urandom_range(5, 1));
                score("rnd_bounce");
            end else begin
                restart_pulse($urandom_range(4, 1));
                score("rnd_restart");
            end
        end

        // Asynchronous reset in the middle of a debounce window.
        if (pos_h < 0) begin
            rand_press();
            score("pre_reset");
        end
        next_btn = 1'b1;
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        pos_h = -1;
        pos_a = -1;
        score("reset_mid");
        next_btn = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        score("reset_no_advance");
        rand_press();
        score("reset_then_press");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
